matmul_stream_sequencer: RTL

Initiator-side companion to the 4x4 fixed-point matrix multiply engine. It accepts operand matrices A and B as a single valid/ready element stream and presents them to the engine as parallel arrays. It then issues a one-cycle start, waits for the engine's done, and captures the result C. C is returned as a row-major valid/ready element stream. The block sits between the Kalman-filter stream fabric and the multiply engine.

---
 rtl/matmul_stream_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/matmul_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : matmul_stream_sequencer
// Purpose  : Initiator-side companion to the DIMxDIM matrix multiply engine.
//            Collects A then B (row-major) from a valid/ready element stream,
//            presents them to the engine as parallel arrays, fires a one-cycle
//            start, waits for done (with timeout), captures C and returns it
//            as a row-major valid/ready element stream.
// Ports    : clk, rst_n (async, active-low)
//            s_valid/s_data/s_last/s_ready : operand input stream
//            mm_a, mm_b, mm_start          : operands and start to engine
//            mm_c, mm_done                 : result from engine
//            m_valid/m_data/m_last/m_ready : result output stream
//            busy, err_framing, err_timeout: status
// Revision : 1.0 - initial release
// ============================================================================
module matmul_stream_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int DIM            = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   s_valid,
    input  logic [DATA_WIDTH-1:0]                  s_data,
    input  logic                                   s_last,
    output logic                                   s_ready,
    output logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] mm_a,
    output logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] mm_b,
    output logic                                   mm_start,
    input  logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] mm_c,
    input  logic                                   mm_done,
    output logic                                   m_valid,
    output logic [DATA_WIDTH-1:0]                  m_data,
    output logic                                   m_last,
    input  logic                                   m_ready,
    output logic                                   busy,
    output logic                                   err_framing,
    output logic                                   err_timeout
);

    localparam int N      = DIM * DIM;
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int BEAT_W = $clog2(2 * N);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_LOAD_A = 3'd0;
    localparam logic [2:0] S_LOAD_B = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;

    logic [2:0]                 state;
    logic [2:0]                 state_nxt;
    logic [BEAT_W-1:0]          beat;
    logic [IDX_W-1:0]           elem_idx;
    logic [IDX_W-1:0]           drain_idx;
    logic [TO_W-1:0]            wait_cnt;
    logic [N-1:0][DATA_WIDTH-1:0] a_buf;
    logic [N-1:0][DATA_WIDTH-1:0] b_buf;
    logic [N-1:0][DATA_WIDTH-1:0] c_buf;
    logic                       framing_q;

    logic beat_fire;
    logic last_beat;
    logic frame_err;
    logic out_fire;
    logic drain_end;
    logic timeout_hit;

    assign beat_fire   = s_valid && s_ready;
    assign last_beat   = (beat == BEAT_W'(2 * N - 1));
    // s_last must coincide exactly with the final beat of B
    assign frame_err   = beat_fire && (s_last != last_beat);
    assign out_fire    = m_valid && m_ready;
    assign drain_end   = (drain_idx == IDX_W'(N - 1));
    // A done arriving in the last allowed cycle still wins over the timeout
    assign timeout_hit = (state == S_WAIT) && !mm_done &&
                         (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    // Beats 0..N-1 land in A, beats N..2N-1 in B at the same element slot
    assign elem_idx    = (beat < BEAT_W'(N)) ? IDX_W'(beat) : IDX_W'(beat - BEAT_W'(N));

    assign mm_a        = a_buf;
    assign mm_b        = b_buf;
    assign err_framing = framing_q;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_LOAD_A;
        end else begin
            state <= state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD_A: begin
                if (beat_fire) begin
                    if (frame_err) begin
                        state_nxt = S_LOAD_A;
                    end else if (beat == BEAT_W'(N - 1)) begin
                        state_nxt = S_LOAD_B;
                    end
                end
            end
            S_LOAD_B: begin
                if (beat_fire) begin
                    if (frame_err) begin
                        state_nxt = S_LOAD_A;
                    end else if (last_beat) begin
                        state_nxt = S_START;
                    end
                end
            end
            S_START: state_nxt = S_WAIT;
            S_WAIT: begin
                if (mm_done) begin
                    state_nxt = S_DRAIN;
                end else if (timeout_hit) begin
                    state_nxt = S_LOAD_A;
                end
            end
            S_DRAIN: begin
                if (out_fire && drain_end) begin
                    state_nxt = S_LOAD_A;
                end
            end
            default: state_nxt = S_LOAD_A;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        s_ready     = (state == S_LOAD_A) || (state == S_LOAD_B);
        mm_start    = (state == S_START);
        m_valid     = (state == S_DRAIN);
        m_last      = (state == S_DRAIN) && drain_end;
        m_data      = c_buf[drain_idx];
        busy        = !((state == S_LOAD_A) && (beat == '0));
        err_timeout = timeout_hit;
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat      <= '0;
            a_buf     <= '0;
            b_buf     <= '0;
            c_buf     <= '0;
            drain_idx <= '0;
            wait_cnt  <= '0;
            framing_q <= 1'b0;
        end else begin
            framing_q <= frame_err;

            if (beat_fire) begin
                // A bad frame restarts from beat 0; operand contents are left
                // as written and get overwritten by the next frame.
                beat <= (frame_err || last_beat) ? '0 : beat + BEAT_W'(1);
                if (beat < BEAT_W'(N)) begin
                    a_buf[elem_idx] <= s_data;
                end else begin
                    b_buf[elem_idx] <= s_data;
                end
            end

            if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + TO_W'(1);
            end else begin
                wait_cnt <= '0;
            end

            if ((state == S_WAIT) && mm_done) begin
                c_buf <= mm_c;
            end

            if (out_fire) begin
                drain_idx <= drain_end ? '0 : drain_idx + IDX_W'(1);
            end
        end
    end

endmodule
`default_nettype wire
